// File: rtl/ibuf_pkg.sv
// Shared sizing, entry/pointer types and pointer arithmetic for the
// instruction buffer between pre-decode and decode.
package ibuf_pkg;

  localparam int DEPTH           = 32;
  localparam int BLOCK_INST_SIZE = 8;
  localparam int FETCH_WIDTH     = 4;
  localparam int FSQ_WIDTH       = 4;
  localparam int OFS_WIDTH       = $clog2(BLOCK_INST_SIZE);
  localparam int IDX_WIDTH       = $clog2(DEPTH);
  localparam int CNT_WIDTH       = IDX_WIDTH + 1;
  localparam int ENQ_WIDTH       = $clog2(BLOCK_INST_SIZE + 1);

  typedef struct packed {
    logic [31:0]           inst;
    logic [FSQ_WIDTH-1:0]  fsqIdx;
    logic [OFS_WIDTH-1:0]  offset;
  } IBufEntry;

  typedef struct packed {
    logic                 dir;
    logic [IDX_WIDTH-1:0] idx;
  } ibuf_ptr_t;

  // DEPTH is a power of two, so a plain add carries into the wrap bit.
  function automatic ibuf_ptr_t ptr_add(input ibuf_ptr_t p, input logic [CNT_WIDTH-1:0] n);
    logic [CNT_WIDTH-1:0] sum;
    sum = {p.dir, p.idx} + n;
    return ibuf_ptr_t'(sum);
  endfunction

endpackage

// File: rtl/ibuf_compact.sv
// Prefix-popcount compactor: gives each set slot of a sparse valid mask its
// rank among the set slots, plus the total number of set slots.
module ibuf_compact #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]                  en,
  output logic [WIDTH*$clog2(WIDTH)-1:0]    rank,
  output logic [$clog2(WIDTH+1)-1:0]        enq_num
);

  localparam int RANK_W = $clog2(WIDTH);
  localparam int NUM_W  = $clog2(WIDTH + 1);

  always_comb begin : prefix_sum
    logic [NUM_W-1:0] acc;
    acc  = '0;
    rank = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rank[i*RANK_W +: RANK_W] = acc[RANK_W-1:0];
      acc = acc + NUM_W'(en[i]);
    end
    enq_num = acc;
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue: packs sparse fetch blocks in order and hands up
// to FETCH_WIDTH instructions per cycle to decode.
module inst_buffer
  import ibuf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [BLOCK_INST_SIZE-1:0]       in_en,
  input  logic [BLOCK_INST_SIZE*32-1:0]    in_inst,
  input  logic [FSQ_WIDTH-1:0]             in_fsqIdx,
  output logic                             full,
  input  logic                             stall,
  output logic [FETCH_WIDTH-1:0]           out_en,
  output logic [FETCH_WIDTH*32-1:0]        out_inst,
  output logic [FETCH_WIDTH*FSQ_WIDTH-1:0] out_fsqIdx,
  output logic [FETCH_WIDTH*OFS_WIDTH-1:0] out_offset
);

  IBufEntry                         ram [DEPTH];
  ibuf_ptr_t                        head;
  ibuf_ptr_t                        tail;
  logic [CNT_WIDTH-1:0]             count;
  logic [CNT_WIDTH-1:0]             count_next;
  logic [CNT_WIDTH-1:0]             avail;
  logic [CNT_WIDTH-1:0]             deq_num;
  logic [CNT_WIDTH-1:0]             enq_num;
  logic [ENQ_WIDTH-1:0]             block_num;
  logic [BLOCK_INST_SIZE*OFS_WIDTH-1:0] rank;
  logic [IDX_WIDTH-1:0]             wr_idx [BLOCK_INST_SIZE];
  logic                             enq_fire;

  ibuf_compact #(.WIDTH(BLOCK_INST_SIZE)) u_compact (
    .en      (in_en),
    .rank    (rank),
    .enq_num (block_num)
  );

  assign enq_fire   = |in_en && !full && !flush;
  assign enq_num    = enq_fire ? CNT_WIDTH'(block_num) : '0;
  assign avail      = (count > CNT_WIDTH'(FETCH_WIDTH)) ? CNT_WIDTH'(FETCH_WIDTH) : count;
  assign deq_num    = (!stall && !flush) ? avail : '0;
  assign count_next = count + enq_num - deq_num;

  always_comb begin
    for (int j = 0; j < BLOCK_INST_SIZE; j++) begin
      wr_idx[j] = tail.idx + IDX_WIDTH'(rank[j*OFS_WIDTH +: OFS_WIDTH]);
    end
  end

  // Entry storage carries no reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      for (int j = 0; j < BLOCK_INST_SIZE; j++) begin
        if (in_en[j]) begin
          ram[wr_idx[j]] <= '{inst:   in_inst[j*32 +: 32],
                              fsqIdx: in_fsqIdx,
                              offset: OFS_WIDTH'(j)};
        end
      end
    end
  end

  always_comb begin
    out_en     = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    out_offset = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      logic [IDX_WIDTH-1:0] rd_idx;
      rd_idx = head.idx + IDX_WIDTH'(i);
      out_en[i]                             = CNT_WIDTH'(i) < avail;
      out_inst[i*32 +: 32]                  = ram[rd_idx].inst;
      out_fsqIdx[i*FSQ_WIDTH +: FSQ_WIDTH]  = ram[rd_idx].fsqIdx;
      out_offset[i*OFS_WIDTH +: OFS_WIDTH]  = ram[rd_idx].offset;
    end
  end

  // full looks one block ahead so that full=0 always admits a whole block.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      head  <= ptr_add(head, deq_num);
      tail  <= ptr_add(tail, enq_num);
      count <= count_next;
      full  <= count_next > CNT_WIDTH'(DEPTH - BLOCK_INST_SIZE);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_inst_buffer;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [7:0]   in_en;
  logic [255:0] in_inst;
  logic [3:0]   in_fsqIdx;
  logic         full;
  logic         stall;
  logic [3:0]   out_en;
  logic [127:0] out_inst;
  logic [15:0]  out_fsqIdx;
  logic [11:0]  out_offset;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  fsq;
    logic [2:0]  ofs;
  } ref_t;

  ref_t model[$];
  bit   mFull;
  bit   checkOn;
  int   checks;
  int   errors;
  int   blkNum;
  int   mAvail;

  inst_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_en      (in_en),
    .in_inst    (in_inst),
    .in_fsqIdx  (in_fsqIdx),
    .full       (full),
    .stall      (stall),
    .out_en     (out_en),
    .out_inst   (out_inst),
    .out_fsqIdx (out_fsqIdx),
    .out_offset (out_offset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] makeInst(input int blk, input int j);
    return 32'h1000_0000 + 32'(blk * 256 + j);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns just after the capturing edge.
  task automatic applyStimulus(input logic [7:0] en, input logic [3:0] fsq,
                               input logic st, input logic fl, input logic rs);
    rst       = rs;
    flush     = fl;
    stall     = st;
    in_en     = en;
    in_fsqIdx = fsq;
    for (int j = 0; j < 8; j++) in_inst[j*32 +: 32] = makeInst(blkNum, j);
    blkNum++;
    @(posedge clk);
    #1;
  endtask

  // Reference model: check outputs against the queue, then advance it.
  always @(negedge clk) begin
    mAvail = (model.size() > 4) ? 4 : model.size();
    if (checkOn) begin
      checkOutput("out_en", 32'(out_en), 32'((1 << mAvail) - 1));
      checkOutput("full", 32'(full), 32'(mFull));
      for (int i = 0; i < mAvail; i++) begin
        checkOutput($sformatf("slot%0d inst", i), out_inst[i*32 +: 32], model[i].inst);
        checkOutput($sformatf("slot%0d fsqIdx", i), 32'(out_fsqIdx[i*4 +: 4]), 32'(model[i].fsq));
        checkOutput($sformatf("slot%0d offset", i), 32'(out_offset[i*3 +: 3]), 32'(model[i].ofs));
      end
    end
    if (rst) begin
      model.delete();
      mFull   = 1'b0;
      checkOn = 1'b1;
    end else if (flush) begin
      model.delete();
      mFull = 1'b0;
    end else begin
      if (!stall) repeat (mAvail) void'(model.pop_front());
      if (in_en != 8'h00) begin
        if (mFull) begin
          $display("[TB] protocol violation: block presented while full, expected to be ignored");
        end else begin
          for (int j = 0; j < 8; j++) begin
            if (in_en[j]) model.push_back('{inst: in_inst[j*32 +: 32], fsq: in_fsqIdx, ofs: 3'(j)});
          end
        end
      end
      mFull = model.size() > 24;
    end
  end

  initial begin
    logic [7:0] masks [10];
    logic [7:0] en;
    masks = '{8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3, 8'hFF, 8'h3C, 8'h81, 8'hFF, 8'h10};
    checks  = 0;
    errors  = 0;
    blkNum  = 0;
    checkOn = 1'b0;
    mFull   = 1'b0;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_en = '0; in_inst = '0; in_fsqIdx = '0;

    // Reset (blocks 0,1)
    applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset out_en", 32'(out_en), 32'h0);
    checkOutput("reset full", 32'(full), 32'h0);

    // Sparse block 2: slots 1,2,5,7
    applyStimulus(8'b1010_0110, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("sparse out_en", 32'(out_en), 32'hF);
    checkOutput("sparse offsets", 32'(out_offset), 32'hF51);
    checkOutput("sparse fsqIdx", 32'(out_fsqIdx), 32'h3333);
    checkOutput("sparse slot0 inst", out_inst[31:0], 32'h1000_0201);
    checkOutput("sparse slot3 inst", out_inst[127:96], 32'h1000_0207);
    applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sparse drained", 32'(out_en), 32'h0);

    // Fill to full under stall
    for (int b = 0; b < 4; b++) begin
      applyStimulus(8'hFF, 4'(b), 1'b1, 1'b0, 1'b0);
      if (b == 2) checkOutput("full at 24", 32'(full), 32'h0);
    end
    checkOutput("full at 32", 32'(full), 32'h1);
    checkOutput("frozen offsets", 32'(out_offset), 32'h688);
    checkOutput("frozen fsqIdx", 32'(out_fsqIdx), 32'h0000);
    applyStimulus(8'hFF, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("ignored while full", 32'(full), 32'h1);
    applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("full at 28", 32'(full), 32'h1);
    checkOutput("second half offsets", 32'(out_offset), 32'hFAC);
    applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("full drops at 24", 32'(full), 32'h0);
    repeat (8) applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    // Mixed masks across the wrap boundary
    for (int i = 0; i < 40; i++) begin
      en = mFull ? 8'h00 : masks[i % 10];
      applyStimulus(en, 4'(i), (i % 7) == 3, 1'b0, 1'b0);
    end
    repeat (20) applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap drained", 32'(out_en), 32'h0);

    // Flush with a same-cycle enqueue at count=10
    applyStimulus(8'hFF, 4'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h03, 4'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("count10 full", 32'(full), 32'h0);
    applyStimulus(8'hFF, 4'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("flush out_en", 32'(out_en), 32'h0);
    checkOutput("flush full", 32'(full), 32'h0);
    repeat (3) applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("dropped block absent", 32'(out_en), 32'h0);

    // Reset overriding flush and enqueue
    applyStimulus(8'h07, 4'd6, 1'b1, 1'b0, 1'b0);
    checkOutput("three queued", 32'(out_en), 32'h7);
    applyStimulus(8'hFF, 4'd7, 1'b0, 1'b1, 1'b1);
    checkOutput("rst out_en", 32'(out_en), 32'h0);
    checkOutput("rst full", 32'(full), 32'h0);
    applyStimulus(8'h01, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("post-rst out_en", 32'(out_en), 32'h1);
    checkOutput("post-rst offset", 32'(out_offset[2:0]), 32'h0);
    checkOutput("post-rst fsqIdx", 32'(out_fsqIdx[3:0]), 32'h8);
    repeat (2) applyStimulus(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
